// File: rtl/sysregs_pkg.sv
// Shared definitions for the system register block.
// Contents: register word offsets, interrupt bit indices, register reset
// constants, the handshake FSM state type and a byte-lane merge helper.
package sysregs_pkg;

  // Word offsets inside the 0x600xx window (byte address with bit 0 cleared).
  localparam logic [7:0] REG_DISP_START = 8'h00;
  localparam logic [7:0] REG_MOUSE_X    = 8'h02;
  localparam logic [7:0] REG_MOUSE_Y    = 8'h04;
  localparam logic [7:0] REG_MOUSE_BTN  = 8'h06;
  localparam logic [7:0] REG_IRQ_STATUS = 8'h08;
  localparam logic [7:0] REG_IRQ_ENABLE = 8'h0A;
  localparam logic [7:0] REG_FRAME_CNT  = 8'h0C;
  localparam logic [7:0] REG_SCRATCH    = 8'h0E;

  // Interrupt status / enable bit positions.
  localparam int IRQ_VBL = 0;
  localparam int IRQ_BTN = 1;

  // Reset values of the plain registers (DISP_START is a module parameter).
  localparam logic [15:0] FRAME_RESET   = 16'h0000;
  localparam logic [15:0] SCRATCH_RESET = 16'h0000;
  localparam logic [9:0]  MOUSE_RESET   = 10'h000;
  localparam logic [1:0]  IRQ_RESET     = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Byte-lane write merge: strb[1] selects D15:8, strb[0] selects D7:0.
  function automatic logic [15:0] apply_wstrb(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  strb);
    logic [15:0] r;
    r = old_v;
    if (strb[0]) r[7:0]  = new_v[7:0];
    if (strb[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

endpackage

// File: rtl/sysregs_if.sv
// Register-port bundle between the CPU bus decoder (master) and the
// system register responder (slave).
//
// Handshake: the master raises regs_req for exactly one cycle with
// addr/we/wstrb/wdata valid in that same cycle, and issues no further req
// until it has seen regs_ack. The slave answers with a one-cycle regs_ack;
// regs_rdata is valid in the ack cycle and held until the next ack.
interface sysregs_if;
  logic        regs_req;
  logic [7:0]  regs_addr;
  logic [15:0] regs_wdata;
  logic [1:0]  regs_wstrb;
  logic        regs_we;
  logic        regs_ack;
  logic [15:0] regs_rdata;

  modport master (
    output regs_req, regs_addr, regs_wdata, regs_wstrb, regs_we,
    input  regs_ack, regs_rdata
  );

  modport slave (
    input  regs_req, regs_addr, regs_wdata, regs_wstrb, regs_we,
    output regs_ack, regs_rdata
  );
endinterface

// File: rtl/sysregs_irq.sv
// Interrupt side of the system registers.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   vblank              vertical blank level (clk domain)
//   mouse_btn           asynchronous buttons, two-flop synchronised here
//   wr_stat, wr_en_reg  CPU write strobes (ack cycle, low byte enabled)
//   wr_bits             CPU write data bits [1:0]
//   vbl_edge            one-cycle strobe on a vblank rising edge
//   btn_sync            synchronised button value
//   status_nxt          IRQ_STATUS value after this cycle's updates
//   enable              IRQ_ENABLE
//   irq                 registered |(IRQ_STATUS & IRQ_ENABLE)
module sysregs_irq
  import sysregs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic [2:0] mouse_btn,
  input  logic       wr_stat,
  input  logic       wr_en_reg,
  input  logic [1:0] wr_bits,
  output logic       vbl_edge,
  output logic [2:0] btn_sync,
  output logic [1:0] status_nxt,
  output logic [1:0] enable,
  output logic       irq
);

  logic       vbl_q;
  logic [2:0] btn_meta;
  logic [2:0] btn_prev;
  logic [1:0] status_q;
  logic [1:0] hw_set;
  logic [1:0] w1c;

  assign vbl_edge = vblank & ~vbl_q;

  // Hardware sets are OR-ed in after the clear, so a set wins over a
  // same-cycle write-1-to-clear of the same bit.
  always_comb begin
    hw_set          = '0;
    hw_set[IRQ_VBL] = vbl_edge;
    hw_set[IRQ_BTN] = (btn_sync != btn_prev);
    w1c             = wr_stat ? wr_bits : 2'b00;
    status_nxt      = hw_set | (status_q & ~w1c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbl_q    <= 1'b0;
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      status_q <= IRQ_RESET;
      enable   <= IRQ_RESET;
      irq      <= 1'b0;
    end else begin
      vbl_q    <= vblank;
      btn_meta <= mouse_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      status_q <= status_nxt;
      if (wr_en_reg) enable <= wr_bits;
      // Built from the registered status/enable, so irq follows one cycle later.
      irq      <= |(status_q & enable);
    end
  end

endmodule

// File: rtl/sysregs.sv
// System register responder on the CPU bus regs_* port (window 0x600xx).
// Ports:
//   clk, rst_n        clock / async active-low reset
//   bus               sysregs_if slave: req/addr/wdata/wstrb/we in, ack/rdata out
//   vblank            vertical blank level
//   mouse_x/y         live mouse position, snapshotted on vblank rising edge
//   mouse_btn         asynchronous mouse buttons
//   disp_start        display fetch base {DISP_START, 2'b00}
//   irq               CPU interrupt line
//   dbg_state         handshake FSM state
module sysregs
  import sysregs_pkg::*;
#(
  parameter int unsigned ACK_DELAY  = 1,
  parameter logic [15:0] DISP_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  sysregs_if.slave    bus,
  input  logic        vblank,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic [2:0]  mouse_btn,
  output logic [17:0] disp_start,
  output logic        irq,
  output state_t      dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(ACK_DELAY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_en;
  logic        ack;

  logic [7:0]  addr_q;
  logic        we_q;
  logic [1:0]  wstrb_q;
  logic [15:0] wdata_q;

  logic [15:0] disp_q, disp_d;
  logic [9:0]  mx_q, mx_d, my_q, my_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] scratch_q, scratch_d;
  logic [15:0] rdata_q, rd_mux;

  logic        wr_fire;
  logic [7:0]  waddr;
  logic        vbl_edge;
  logic [2:0]  btn_sync;
  logic [1:0]  status_nxt;
  logic [1:0]  irq_en;

  // ---------------- handshake FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.regs_req) begin
          cap_en  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_en) begin
        addr_q  <= bus.regs_addr;
        we_q    <= bus.regs_we;
        wstrb_q <= bus.regs_wstrb;
        wdata_q <= bus.regs_wdata;
      end
    end
  end

  assign dbg_state = state_q;

  // ---------------- register file ----------------
  assign wr_fire = ack & we_q;
  assign waddr   = addr_q & 8'hFE;  // byte-address bit 0 is ignored

  sysregs_irq u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblank     (vblank),
    .mouse_btn  (mouse_btn),
    .wr_stat    (wr_fire && waddr == REG_IRQ_STATUS && wstrb_q[0]),
    .wr_en_reg  (wr_fire && waddr == REG_IRQ_ENABLE && wstrb_q[0]),
    .wr_bits    (wdata_q[1:0]),
    .vbl_edge   (vbl_edge),
    .btn_sync   (btn_sync),
    .status_nxt (status_nxt),
    .enable     (irq_en),
    .irq        (irq)
  );

  // Next values; a CPU write to FRAME_COUNT overrides a same-cycle increment.
  always_comb begin
    disp_d    = disp_q;
    scratch_d = scratch_q;
    mx_d      = vbl_edge ? mouse_x : mx_q;
    my_d      = vbl_edge ? mouse_y : my_q;
    frame_d   = vbl_edge ? frame_q + 16'd1 : frame_q;
    if (wr_fire) begin
      case (waddr)
        REG_DISP_START: disp_d    = apply_wstrb(disp_q, wdata_q, wstrb_q);
        REG_FRAME_CNT:  frame_d   = apply_wstrb(frame_q, wdata_q, wstrb_q);
        REG_SCRATCH:    scratch_d = apply_wstrb(scratch_q, wdata_q, wstrb_q);
        default: ;
      endcase
    end
  end

  // Read mux looks at next values so a same-cycle hardware update is seen.
  always_comb begin
    rd_mux = '0;
    case (waddr)
      REG_DISP_START: rd_mux = disp_d;
      REG_MOUSE_X:    rd_mux = {6'b0, mx_d};
      REG_MOUSE_Y:    rd_mux = {6'b0, my_d};
      REG_MOUSE_BTN:  rd_mux = {13'b0, btn_sync};
      REG_IRQ_STATUS: rd_mux = {14'b0, status_nxt};
      REG_IRQ_ENABLE: rd_mux = {14'b0, irq_en};
      REG_FRAME_CNT:  rd_mux = frame_d;
      REG_SCRATCH:    rd_mux = scratch_d;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q    <= DISP_RESET;
      mx_q      <= MOUSE_RESET;
      my_q      <= MOUSE_RESET;
      frame_q   <= FRAME_RESET;
      scratch_q <= SCRATCH_RESET;
      rdata_q   <= '0;
    end else begin
      disp_q    <= disp_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      frame_q   <= frame_d;
      scratch_q <= scratch_d;
      if (ack) rdata_q <= rd_mux;
    end
  end

  assign bus.regs_ack   = ack;
  assign bus.regs_rdata = ack ? rd_mux : rdata_q;
  assign disp_start     = {disp_q, 2'b00};

endmodule

// File: tb/tb_sysregs.sv
// Self-checking bench for sysregs: randomized and directed register traffic
// against a register-level reference model, with a scoreboard queue popped
// by a monitor on every ack.
module tb_sysregs;
  import sysregs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sysregs_if bus ();
  sysregs_if bus3 ();

  logic        vblank = 1'b0;
  logic [9:0]  mouse_x = '0;
  logic [9:0]  mouse_y = '0;
  logic [2:0]  mouse_btn = '0;
  logic [17:0] disp_start, disp_start3;
  logic        irq, irq3;
  state_t      dbg_state, dbg_state3;

  sysregs #(.ACK_DELAY(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .vblank(vblank),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
    .disp_start(disp_start), .irq(irq), .dbg_state(dbg_state)
  );

  sysregs #(.ACK_DELAY(3), .DISP_RESET(16'h1234)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .vblank(1'b0),
    .mouse_x(10'h0), .mouse_y(10'h0), .mouse_btn(3'b000),
    .disp_start(disp_start3), .irq(irq3), .dbg_state(dbg_state3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The decoder never issues a request while a transaction is outstanding.
  always @(posedge clk) begin
    if (rst_n && bus.regs_req)
      assert (dbg_state == ST_IDLE) else $error("regs_req issued while busy");
  end

  // ---------------- reference model ----------------
  logic [15:0] m_disp = 16'h0000;
  logic [9:0]  m_mx = '0, m_my = '0;
  logic [2:0]  m_btn = '0;
  logic [1:0]  m_stat = '0, m_en = '0;
  logic [15:0] m_frame = '0, m_scr = '0;

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = o;
    if (s[0]) r[7:0]  = n[7:0];
    if (s[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  function automatic logic [15:0] model_rd(input logic [7:0] a);
    case (a & 8'hFE)
      8'h00:   return m_disp;
      8'h02:   return {6'b0, m_mx};
      8'h04:   return {6'b0, m_my};
      8'h06:   return {13'b0, m_btn};
      8'h08:   return {14'b0, m_stat};
      8'h0A:   return {14'b0, m_en};
      8'h0C:   return m_frame;
      8'h0E:   return m_scr;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_wr(input logic [7:0] a, input logic [1:0] s, input logic [15:0] d);
    case (a & 8'hFE)
      8'h00: m_disp = merge(m_disp, d, s);
      8'h08: if (s[0]) m_stat = m_stat & ~d[1:0];
      8'h0A: if (s[0]) m_en = d[1:0];
      8'h0C: m_frame = merge(m_frame, d, s);
      8'h0E: m_scr = merge(m_scr, d, s);
      default: ;
    endcase
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Entry: {is_read, expected rdata}
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && bus.regs_ack) begin
      check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[16]) check("rdata", bus.regs_rdata, e[15:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic txn(input logic [7:0] a, input logic we, input logic [1:0] s,
                     input logic [15:0] d, input logic [15:0] exp_rd, input bit vbl_at_ack);
    int lat;
    bit got;
    exp_q.push_back({~we, exp_rd});
    @(negedge clk);
    bus.regs_req = 1'b1; bus.regs_addr = a; bus.regs_we = we;
    bus.regs_wstrb = s; bus.regs_wdata = d;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      bus.regs_req = 1'b0;
      lat++;
      if (bus.regs_ack) begin
        got = 1;
        if (vbl_at_ack) vblank = 1'b1;
      end
    end
    check("ack_latency", lat, 1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] s, input logic [15:0] d);
    txn(a, 1'b1, s, d, 16'h0, 1'b0);
    model_wr(a, s, d);
  endtask

  task automatic rd(input logic [7:0] a);
    txn(a, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), model_rd(a), 1'b0);
  endtask

  task automatic vbl_pulse();
    @(negedge clk) vblank = 1'b1;
    m_frame = m_frame + 16'd1; m_mx = mouse_x; m_my = mouse_y; m_stat[0] = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Write whose commit edge coincides with a vblank rising edge.
  task automatic wr_vbl(input logic [7:0] a, input logic [1:0] s, input logic [15:0] d);
    logic [15:0] f_inc;
    f_inc = m_frame + 16'd1;
    txn(a, 1'b1, s, d, 16'h0, 1'b1);
    model_wr(a, s, d);
    if ((a & 8'hFE) != 8'h0C) m_frame = f_inc;
    m_mx = mouse_x; m_my = mouse_y; m_stat[0] = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_irq(input string name);
    repeat (2) @(negedge clk);
    check(name, irq, |(m_stat & m_en));
  endtask

  // Transaction on the ACK_DELAY=3 instance; returns latency and rdata.
  task automatic txn3(input logic [7:0] a, input logic we, input logic [15:0] d,
                      output int lat, output logic [15:0] rdata);
    bit got;
    @(negedge clk);
    bus3.regs_req = 1'b1; bus3.regs_addr = a; bus3.regs_we = we;
    bus3.regs_wstrb = 2'b11; bus3.regs_wdata = d;
    lat = 0; got = 0; rdata = 'x;
    while (!got && lat < 20) begin
      @(negedge clk);
      bus3.regs_req = 1'b0;
      lat++;
      if (bus3.regs_ack) begin got = 1; rdata = bus3.regs_rdata; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] rd3;
    bit ack_seen;
    bus.regs_req = 0; bus.regs_addr = 0; bus.regs_we = 0; bus.regs_wstrb = 0; bus.regs_wdata = 0;
    bus3.regs_req = 0; bus3.regs_addr = 0; bus3.regs_we = 0; bus3.regs_wstrb = 0; bus3.regs_wdata = 0;

    repeat (3) @(negedge clk);
    check("rst_ack", bus.regs_ack, 1'b0);
    check("rst_rdata", bus.regs_rdata, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_disp_start", disp_start, 18'h0);
    check("rst_disp_start3", disp_start3, {16'h1234, 2'b00});
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    rd(8'h00);
    txn3(8'h00, 1'b0, 16'h0, lat, rd3);
    check("lat_delay3", lat, 3);
    check("rdata_delay3", rd3, 16'h1234);

    // Byte-lane writes to SCRATCH
    wr(8'h0E, 2'b10, 16'hABCD); rd(8'h0E);
    wr(8'h0E, 2'b01, 16'h1234); rd(8'h0E);
    wr(8'h0E, 2'b00, 16'hFFFF); rd(8'h0F);

    // Random traffic; vblank idle, buttons constant, live mouse must not leak
    mouse_x = 10'h3FF; mouse_y = 10'h3C3;
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [7:0] a;
      k = $urandom_range(0, 9);
      a = (k < 8) ? 8'(2 * k + $urandom_range(0, 1)) : 8'($urandom_range(16, 255));
      if ($urandom_range(0, 1) == 1) wr(a, 2'($urandom_range(0, 3)), 16'($urandom));
      else rd(a);
    end
    repeat (2) @(negedge clk);
    check("disp_start_after_random", disp_start, {m_disp, 2'b00});
    check("irq_after_random", irq, |(m_stat & m_en));

    // Vblank edge with snapshot and interrupt
    wr(8'h0A, 2'b11, 16'h0001);
    wr(8'h0C, 2'b11, 16'h0000);
    mouse_x = 10'h155; mouse_y = 10'h2AA;
    vbl_pulse();
    chk_irq("irq_vbl_rise");
    rd(8'h02); rd(8'h04); rd(8'h0C); rd(8'h08);
    wr(8'h08, 2'b01, 16'h0001);
    chk_irq("irq_after_w1c");

    // W1C colliding with a new vblank edge: the set wins
    vbl_pulse();
    chk_irq("irq_before_collide");
    wr_vbl(8'h08, 2'b11, 16'h0001);
    chk_irq("irq_after_collide");
    rd(8'h08);

    // FRAME_COUNT wrap, then CPU write beating the increment
    wr(8'h0C, 2'b11, 16'hFFFF);
    vbl_pulse();
    rd(8'h0C);
    wr_vbl(8'h0C, 2'b11, 16'h0010);
    rd(8'h0C);

    // Button change sets IRQ_STATUS bit1
    wr(8'h0A, 2'b01, 16'h0002);
    @(negedge clk) mouse_btn = 3'b101;
    m_btn = 3'b101; m_stat[1] = 1'b1;
    repeat (6) @(negedge clk);
    rd(8'h06); rd(8'h08);
    chk_irq("irq_btn");

    // Unmapped space
    rd(8'h40); wr(8'h40, 2'b11, 16'hDEAD); rd(8'h41); rd(8'h0E);

    // Reset asserted mid-WAIT on the ACK_DELAY=3 instance
    txn3(8'h00, 1'b1, 16'h00FF, lat, rd3);
    check("lat_write3", lat, 3);
    repeat (2) @(negedge clk);
    check("disp_start3_written", disp_start3, {16'h00FF, 2'b00});
    @(negedge clk);
    bus3.regs_req = 1'b1; bus3.regs_we = 1'b0; bus3.regs_addr = 8'h0E;
    @(negedge clk);
    bus3.regs_req = 1'b0;
    ack_seen = 0;
    @(negedge clk);
    ack_seen |= bus3.regs_ack;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); ack_seen |= bus3.regs_ack; end
    check("rst_rdata3", bus3.regs_rdata, 16'h0);
    check("rst_disp_start3_back", disp_start3, {16'h1234, 2'b00});
    rst_n = 1'b1;
    m_disp = 16'h0000; m_stat = '0; m_en = '0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); ack_seen |= bus3.regs_ack; end
    check("no_ack_after_reset", ack_seen, 1'b0);
    check("state3_idle", dbg_state3, ST_IDLE);
    check("disp_start_main_reset", disp_start, 18'h0);
    check("irq_main_reset", irq, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysregs.md
Name: sysregs

Overview:
- Memory-mapped system register responder on the CPU bus's `regs_*` port (window 0x600xx).
- Completes the req/ack handshake that the bus decoder initiates.
- Holds the display start address, the mouse snapshot, the frame counter and interrupt status/enable.
- Drives the CPU interrupt line and the display-fetch base address.

Parameters:
- ACK_DELAY, 1, cycles from the sampled `regs_req` to the `regs_ack` pulse; legal range 1..15.
- DISP_RESET, 16'h0000, reset value of DISP_START (byte address [17:2]).

Ports:
- clk  in  1  system clock; every flop is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- regs_req  in  1  one-cycle request pulse from the bus decoder
- regs_addr  in  8  byte address; bit 0 is ignored
- regs_wdata  in  16  write data
- regs_wstrb  in  2  byte enables; [1]=D15:8, [0]=D7:0
- regs_we  in  1  1=write, 0=read
- regs_ack  out  1  one-cycle completion pulse
- regs_rdata  out  16  read data; valid in the regs_ack cycle, held until the next ack
- vblank  in  1  vertical blank level, synchronous to clk
- mouse_x  in  10  live mouse X
- mouse_y  in  10  live mouse Y
- mouse_btn  in  3  live buttons, asynchronous; synchronised internally with 2 flops
- disp_start  out  18  {DISP_START, 2'b00}
- irq  out  1  |(IRQ_STATUS & IRQ_ENABLE), registered

Behaviour:
- Reset values:
  - regs_ack=0, regs_rdata=0, irq=0, disp_start={DISP_RESET,2'b00}.
  - All registers 0 except DISP_START.
  - Busy state cleared; any pending ack is dropped.
- Register map, word offsets:
  - 0x00 DISP_START: R/W.
  - 0x02 MOUSE_X: RO, zero-extended.
  - 0x04 MOUSE_Y: RO, zero-extended.
  - 0x06 MOUSE_BTN: RO, bits[2:0] hold the synchronised live value.
  - 0x08 IRQ_STATUS: bit0 vblank, bit1 button change; write-1-to-clear.
  - 0x0A IRQ_ENABLE: R/W, bits[1:0]; other bits read 0.
  - 0x0C FRAME_COUNT: R/W.
  - 0x0E SCRATCH: R/W.
  - 0x10-0xFF: read 0, writes ignored, still acked.
- Handshake FSM: states IDLE and WAIT.
  - IDLE: a sampled regs_req captures addr/we/wstrb/wdata, loads the delay counter with ACK_DELAY-1 and moves to WAIT.
  - WAIT: when the counter reaches 0, pulse regs_ack for exactly one cycle, drive regs_rdata and return to IDLE.
  - Latency: regs_ack rises ACK_DELAY cycles after the req edge; ACK_DELAY=1 means ack in the next cycle.
  - regs_req arriving while in WAIT is ignored. The decoder never issues one, and the bench asserts on it.
- Writes:
  - Committed in the ack cycle.
  - Per-byte masking by wstrb; wstrb=00 is a no-op write that is still acked.
  - On a read, wstrb and wdata are ignored.
- Read data: sampled in the ack cycle, after any same-cycle hardware update has been applied.
- Vblank rising edge (registered edge detect):
  - FRAME_COUNT increments, wrapping 0xFFFF->0x0000.
  - mouse_x/y are snapshotted into MOUSE_X/Y.
  - IRQ_STATUS bit0 is set.
- Button change: synchronised mouse_btn differs from its previous value -> IRQ_STATUS bit1 is set.
- Simultaneous events:
  - A hardware set and a W1C of the same bit in one cycle: set wins, bit stays 1.
  - A FRAME_COUNT CPU write and a vblank increment in one cycle: the CPU write wins, and that increment is lost.
  - A DISP_START write takes effect on disp_start the cycle after ack.
- irq is updated one cycle after a status or enable change.
- Reset asserted mid-WAIT: no ack is issued; after release the block is in IDLE.

Decomposition:
- Package sysregs_pkg:
  - Register offset localparams: REG_DISP_START..REG_SCRATCH.
  - IRQ bit indices: IRQ_VBL=0, IRQ_BTN=1.
  - Register reset constants.
- One sub-module, sysregs_irq:
  - Contains the vblank edge detector, the button synchroniser and change detector, and IRQ_STATUS/IRQ_ENABLE with W1C.
  - Outputs the vbl_edge strobe and irq.
- The top module holds the handshake FSM, the register file and the read mux.

Test Plan:
- Reset release, read 0x00 with ACK_DELAY=1 -> ack in cycle+1, rdata=DISP_RESET, disp_start=18'h0; with ACK_DELAY=3 -> ack exactly 3 cycles after req.
- Write 0x0E data=0xABCD with wstrb=10, then read 0x0E -> rdata=0xAB00; write data=0x1234 with wstrb=01, then read -> 0xAB34.
- Vblank edge with mouse_x=0x155, mouse_y=0x2AA, IRQ_ENABLE=0x0001:
  - irq rises.
  - MOUSE_X reads 0x0155, MOUSE_Y reads 0x02AA.
  - FRAME_COUNT goes 0->1.
  - Write 0x0001 to 0x08 -> irq falls the next cycle.
- W1C of bit0 landing in the same cycle as a vblank edge -> IRQ_STATUS bit0 stays 1 and irq stays high.
- FRAME_COUNT preset to 0xFFFF, then a vblank edge -> reads 0x0000; a CPU write of 0x0010 coinciding with an edge -> reads 0x0010.
- Read 0x40 -> ack with rdata=0; assert rst_n low during WAIT -> no ack, regs_rdata=0, DISP_START back to DISP_RESET.
